// File: rtl/spi_pkg.sv
// Shared SPI core definitions: core mode encodings and the baud divisor width.
// Used by the baud generator, the APB slave interface and the slave-select block.
package spi_pkg;

  localparam logic [1:0] SPI_RUN  = 2'b00;
  localparam logic [1:0] SPI_WAIT = 2'b01;
  localparam logic [1:0] SPI_STOP = 2'b10;

  localparam int BAUD_DIV_W = 12;

endpackage

// File: rtl/spi_baud_generator.sv
// SPI serial clock divider. Emits launch/sample strobes one PCLK cycle ahead of each SCLK edge.
// SCLK is held at the CPOL idle level whenever no transfer is running.
module spi_baud_generator
  import spi_pkg::*;
(
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  ss_i,
  input  logic [1:0]            spi_mode_i,
  input  logic                  spiswai_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic [2:0]            sppr_i,
  input  logic [2:0]            spr_i,
  output logic                  sclk_o,
  output logic                  miso_receive_sclk_o,
  output logic                  miso_receive_sclk0_o,
  output logic                  mosi_send_sclk_o,
  output logic                  mosi_send_sclk0_o,
  output logic [BAUD_DIV_W-1:0] baudratedivisor_o
);

  localparam int CNT_W = BAUD_DIV_W - 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] half, half_m1;
  logic             sclk_q, sclk_d;
  logic             running, edge_hit, sample_rise, rise_next;

  // (sppr+1) peaks at 8 and the shift at 8, so 2048 is the largest divisor and fits.
  assign baudratedivisor_o = BAUD_DIV_W'({1'b0, sppr_i} + 4'd1) << ({1'b0, spr_i} + 4'd1);
  assign half              = baudratedivisor_o[BAUD_DIV_W-1:1];
  assign half_m1           = half - CNT_W'(1);

  assign running = !ss_i && ((spi_mode_i == SPI_RUN) ||
                             ((spi_mode_i == SPI_WAIT) && !spiswai_i));

  // >= so that a divisor shrinking mid-phase forces an edge instead of a long wrap.
  assign edge_hit    = running && (count_q >= half_m1);
  assign sample_rise = (cpha_i == cpol_i);
  assign rise_next   = !sclk_q;

  always_comb begin
    count_d = count_q;
    sclk_d  = sclk_q;
    if (!running) begin
      count_d = '0;
      sclk_d  = cpol_i;
    end else if (edge_hit) begin
      count_d = '0;
      sclk_d  = ~sclk_q;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      count_q <= '0;
      sclk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sclk_q  <= sclk_d;
    end
  end

  assign sclk_o               = sclk_q;
  assign miso_receive_sclk_o  = edge_hit &&  rise_next &&  sample_rise;
  assign miso_receive_sclk0_o = edge_hit && !rise_next && !sample_rise;
  assign mosi_send_sclk_o     = edge_hit && !rise_next &&  sample_rise;
  assign mosi_send_sclk0_o    = edge_hit &&  rise_next && !sample_rise;

endmodule

// File: tb/tb_spi_baud_generator.sv
// Randomized and directed bench for spi_baud_generator with a queue-based scoreboard.
// The reference model tracks SCLK phases by absolute cycle time.
module tb_spi_baud_generator;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        ss_i;
  logic [1:0]  spi_mode_i;
  logic        spiswai_i;
  logic        cpol_i;
  logic        cpha_i;
  logic [2:0]  sppr_i;
  logic [2:0]  spr_i;
  logic        sclk_o;
  logic        miso_receive_sclk_o;
  logic        miso_receive_sclk0_o;
  logic        mosi_send_sclk_o;
  logic        mosi_send_sclk0_o;
  logic [11:0] baudratedivisor_o;

  spi_baud_generator dut (
    .PCLK                 (PCLK),
    .PRESET               (PRESET),
    .ss_i                 (ss_i),
    .spi_mode_i           (spi_mode_i),
    .spiswai_i            (spiswai_i),
    .cpol_i               (cpol_i),
    .cpha_i               (cpha_i),
    .sppr_i               (sppr_i),
    .spr_i                (spr_i),
    .sclk_o               (sclk_o),
    .miso_receive_sclk_o  (miso_receive_sclk_o),
    .miso_receive_sclk0_o (miso_receive_sclk0_o),
    .mosi_send_sclk_o     (mosi_send_sclk_o),
    .mosi_send_sclk0_o    (mosi_send_sclk0_o),
    .baudratedivisor_o    (baudratedivisor_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int       cyc;
    logic     sclk;
    logic [3:0] strb;   // {miso_rx, miso_rx0, mosi_tx, mosi_tx0}
    logic [11:0] div;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   drv_done = 0;

  // Model state: SCLK level and the cycle at which the current phase began.
  logic m_sclk;
  int   m_phase_start;
  int   tcyc;

  task automatic step();
    exp_t e;
    int   div, half, elapsed;
    bit   run, edge_now, rising, srise;
    div      = (int'(sppr_i) + 1) * (1 << (int'(spr_i) + 1));
    half     = div / 2;
    run      = !ss_i && (spi_mode_i == 2'b00 || (spi_mode_i == 2'b01 && !spiswai_i));
    elapsed  = tcyc - m_phase_start + 1;
    edge_now = run && !PRESET ? (elapsed >= half) : (run && elapsed >= half);
    rising   = (m_sclk == 1'b0);
    srise    = (cpha_i == cpol_i);
    e.cyc    = tcyc;
    e.sclk   = m_sclk;
    e.div    = 12'(div);
    e.strb   = {edge_now && rising && srise, edge_now && !rising && !srise,
                edge_now && !rising && srise, edge_now && rising && !srise};
    exp_q.push_back(e);
    if (PRESET) begin
      m_sclk = 1'b0;
      m_phase_start = tcyc + 1;
    end else if (!run) begin
      m_sclk = cpol_i;
      m_phase_start = tcyc + 1;
    end else if (edge_now) begin
      m_sclk = ~m_sclk;
      m_phase_start = tcyc + 1;
    end
    tcyc++;
    @(posedge PCLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input logic [1:0] mode, input logic swai, input logic pol,
                     input logic pha, input logic [2:0] pp, input logic [2:0] p);
    spi_mode_i = mode; spiswai_i = swai; cpol_i = pol; cpha_i = pha;
    sppr_i = pp; spr_i = p;
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queue head.
  always @(negedge PCLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e   = exp_q.pop_front();
      act = {miso_receive_sclk_o, miso_receive_sclk0_o, mosi_send_sclk_o, mosi_send_sclk0_o};
      checks += 4;
      if (sclk_o !== e.sclk) begin
        errors++;
        $display("FAIL sclk cyc=%0d got=%b want=%b", e.cyc, sclk_o, e.sclk);
      end
      if (act !== e.strb) begin
        errors++;
        $display("FAIL strobes cyc=%0d got=%b want=%b", e.cyc, act, e.strb);
      end
      if (baudratedivisor_o !== e.div) begin
        errors++;
        $display("FAIL divisor cyc=%0d got=%0d want=%0d", e.cyc, baudratedivisor_o, e.div);
      end
      if (!$onehot0(act)) begin
        errors++;
        $display("FAIL onehot cyc=%0d got=%b want=at most one", e.cyc, act);
      end
    end
  end

  initial begin
    PRESET = 1'b1;
    ss_i   = 1'b1;
    cfg(2'b00, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    @(posedge PCLK);
    #1;
    m_sclk = 1'b0;
    m_phase_start = 0;
    tcyc = 0;

    // Reset and idle: second reset cycle, then release with cpol=1.
    step();
    PRESET = 1'b0;
    steps(3);

    // Mode 0, divisor 12.
    ss_i = 1'b1; cfg(2'b00, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1); step();
    ss_i = 1'b0; steps(40);

    // Mode 3 and mode 1 at divisor 2.
    ss_i = 1'b1; cfg(2'b00, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0); steps(2);
    ss_i = 1'b0; steps(10);
    ss_i = 1'b1; cfg(2'b00, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0); steps(2);
    ss_i = 1'b0; steps(10);

    // Maximum divisor: first edge after 1024 cycles.
    ss_i = 1'b1; cfg(2'b00, 1'b0, 1'b0, 1'b0, 3'd7, 3'd7); steps(2);
    ss_i = 1'b0; steps(1100);

    // Wait mode: runs, halts mid-phase, restarts.
    ss_i = 1'b1; cfg(2'b01, 1'b0, 1'b1, 1'b0, 3'd1, 3'd1); steps(2);
    ss_i = 1'b0; steps(13);
    spiswai_i = 1'b1; steps(5);
    spiswai_i = 1'b0; steps(12);

    // Stop mode never runs.
    spi_mode_i = 2'b10; steps(10);

    // Abort on a strobe cycle (divisor 4: first strobe in cycle 2).
    ss_i = 1'b1; cfg(2'b00, 1'b0, 1'b0, 1'b0, 3'd0, 3'd1); steps(2);
    ss_i = 1'b0; step();
    ss_i = 1'b1; steps(4);

    // Divisor shrink 12 -> 4 when count reaches 4.
    cfg(2'b00, 1'b0, 1'b0, 1'b0, 3'd2, 3'd1); step();
    ss_i = 1'b0; steps(5);
    sppr_i = 3'd0; spr_i = 3'd1; steps(10);

    // Randomized traffic; polarity/phase change only while deselected.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) ss_i = ~ss_i;
      if ($urandom_range(0, 59) == 0) spi_mode_i = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) spiswai_i = ~spiswai_i;
      if ($urandom_range(0, 79) == 0) begin
        sppr_i = 3'($urandom_range(0, 3));
        spr_i  = 3'($urandom_range(0, 2));
      end
      if (ss_i && $urandom_range(0, 9) == 0) begin
        cpol_i = 1'($urandom_range(0, 1));
        cpha_i = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 999) == 0) PRESET = 1'b1;
      else PRESET = 1'b0;
      step();
    end
    PRESET = 1'b0;
    drv_done = 1;
  end

  initial begin
    wait (drv_done);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge PCLK);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_baud_generator.md
# spi_baud_generator

Generates the SPI serial clock and the per-edge launch/sample strobes that drive `spi_shifter`, directly upstream of it in the APB SPI core. It divides PCLK by a baud divisor derived from the SPPR/SPR fields of the baud-rate register. It holds SCLK at the CPOL idle level whenever no transfer is active. It tells the shifter, one PCLK cycle ahead, which SCLK edge is about to occur and whether that edge launches MOSI or samples MISO.

## Interface
- No parameters; all widths are fixed by the register map.
- `PCLK` in 1: system clock. One clock domain; all state updates on the rising edge.
- `PRESET` in 1: reset, synchronous and active-high.
- `ss_i` in 1: slave select from the slave-select block, active low. `0` means a transfer is in progress.
- `spi_mode_i` in 2: core mode, one of `SPI_RUN`, `SPI_WAIT` or `SPI_STOP`.
- `spiswai_i` in 1: SPI stop-in-wait. When set, WAIT mode halts the clock.
- `cpol_i` in 1: clock polarity, which is the SCLK idle level.
- `cpha_i` in 1: clock phase.
- `sppr_i` in 3: baud pre-selection.
- `spr_i` in 3: baud selection.
- `sclk_o` out 1: registered serial clock.
- `miso_receive_sclk_o` out 1: strobe for a MISO sample on the upcoming rising SCLK edge.
- `miso_receive_sclk0_o` out 1: strobe for a MISO sample on the upcoming falling SCLK edge.
- `mosi_send_sclk_o` out 1: strobe for a MOSI launch on the upcoming falling SCLK edge.
- `mosi_send_sclk0_o` out 1: strobe for a MOSI launch on the upcoming rising SCLK edge.
- `baudratedivisor_o` out 12: current divisor, readable by the APB slave.

## Operation
- **Divisor.** `baudratedivisor_o = (sppr_i + 1) << (spr_i + 1)`. It is combinational and 12 bits wide.
  - Range is 2 to 2048; the maximum case, sppr=7 and spr=7, equals 2048 and does not overflow 12 bits.
  - `half = divisor >> 1` is the number of PCLK cycles per SCLK phase, range 1 to 1024.
- **Run condition.** `running = !ss_i && (spi_mode_i == SPI_RUN || (spi_mode_i == SPI_WAIT && !spiswai_i))`.
  - `SPI_STOP` never runs.
- **Counter.** `count` is 11 bits.
  - When not running: `count` resets to 0 and `sclk_o` is loaded with `cpol_i`.
  - When running: `edge = (count >= half - 1)`.
    - If `edge`: `count` goes to 0 and `sclk_o` toggles.
    - Otherwise: `count` increments.
  - The `>=` comparison covers a divisor that shrinks mid-transfer: the edge fires immediately and `count` wraps.
- **Strobes.** These are combinational decodes of `running && edge`, qualified by the current `sclk_o` value (rising edge next means `sclk_o == 0`) and by `sample_rise = (cpha_i == cpol_i)`.
  - `miso_receive_sclk_o` = edge, rising next, and `sample_rise`.
  - `miso_receive_sclk0_o` = edge, falling next, and not `sample_rise`.
  - `mosi_send_sclk_o` = edge, falling next, and `sample_rise`.
  - `mosi_send_sclk0_o` = edge, rising next, and not `sample_rise`.
  - At most one strobe is high in any cycle.
- **State machine.** There is no explicit FSM. The implicit states are IDLE (`!running`) and RUN. IDLE to RUN happens on the cycle `running` rises, with `count` starting at 0. RUN to IDLE happens immediately when `running` falls, including mid-phase: SCLK snaps to `cpol_i` on the next edge and no strobe is issued.
- **Reset values.** `sclk_o = 0`, `count = 0`, all strobes 0. `baudratedivisor_o` follows its inputs.
- **Edge counting.** The block does not count edges or bits; byte completion belongs to the slave-select block.

## Timing
- **Strobe alignment.** A strobe is high for exactly one PCLK cycle: the cycle whose closing PCLK edge toggles `sclk_o`. The shifter therefore acts on the same PCLK edge where SCLK changes.
- **First edge.** The first SCLK edge after `ss_i` falls occurs `half` PCLK cycles later. The first strobe is high during cycle `half` (1-based).
- **Steady state.** Toggle period is `half` PCLK cycles; SCLK period is `divisor` PCLK cycles. With divisor 2, a strobe is high every cycle and SCLK toggles every cycle.
- **Simultaneous events.**
  - `ss_i` rising in the same cycle as `edge`: no strobe, and SCLK goes to idle.
  - `PRESET` beats everything.
- **Config changes.** `cpol_i` or `cpha_i` changing while running is undefined and is excluded by software. A `cpol_i` change while idle appears on `sclk_o` one cycle later.

## Structure
- Shared `spi_pkg` holds `SPI_RUN = 2'b00`, `SPI_WAIT = 2'b01`, `SPI_STOP = 2'b10`, and `BAUD_DIV_W = 12`. It is used by this block, the APB slave interface and the slave-select block.
- Single module with no sub-module. The divisor decode is one expression.

## Test plan
- **Reset and idle.** Assert `PRESET` for 2 cycles with `cpol_i = 1` and `ss_i = 1`, then release → `sclk_o = 0` during reset, `sclk_o = 1` one cycle after release, all strobes 0, `baudratedivisor_o = 2`.
- **Mode 0, divisor 12.** `sppr = 2`, `spr = 1`, `cpol = 0`, `cpha = 0`, `ss_i` falls → divisor reads 12. `sclk_o` rises after 6 cycles. `miso_receive_sclk_o` is high in cycle 6 and `mosi_send_sclk_o` in cycle 12, repeating. The 0-suffixed strobes stay low.
- **Mode 3 versus mode 1, divisor 2.**
  - `cpol = 1`, `cpha = 1` → SCLK toggles every cycle, alternating `mosi_send_sclk_o` (falling) and `miso_receive_sclk_o` (rising).
  - `cpol = 0`, `cpha = 1` → `mosi_send_sclk0_o` on rising edges and `miso_receive_sclk0_o` on falling edges.
- **Maximum divisor.** `sppr = 7`, `spr = 7` → `baudratedivisor_o = 2048` and the first edge comes after exactly 1024 cycles.
- **Wait mode.** `spi_mode_i = SPI_WAIT`:
  - `spiswai_i = 0` → SCLK runs.
  - `spiswai_i = 1` mid-phase → `sclk_o` returns to `cpol_i` the next cycle, no strobes, `count` cleared. Deasserting `spiswai_i` restarts with a full `half` delay.
- **Abort and divisor shrink.**
  - Raise `ss_i` on a strobe cycle → no strobe, SCLK idle.
  - Separately, change the divisor from 12 to 4 when `count = 4` → an edge occurs on the next cycle, then every 2 cycles.
